// File: rtl/stack_logic_unit_if.sv
// Command/status bundle between the control unit and the stack logic unit.
// The control unit drives the command side (master); the stack unit answers (slave).
interface stack_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] din;
    logic             op_ready;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [WIDTH-1:0] tos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             zero;
    logic             neg;

    modport master (
        output op_valid, op_code, din,
        input  op_ready, done, err, err_code, tos, count, empty, full, zero, neg
    );

    modport slave (
        input  op_valid, op_code, din,
        output op_ready, done, err, err_code, tos, count, empty, full, zero, neg
    );
endinterface

// File: rtl/stack_logic_unit.sv
// Operand stack with a logical/compare execution FSM, commanded over a valid/ready handshake.
//   state     | meaning
//   S_IDLE    | op_ready=1, waiting for a command; prechecks run on accept
//   S_FETCH_A | read TOS into A (and next-of-stack into B for POP's new top)
//   S_FETCH_B | read next-of-stack into B for binary ops
//   S_EXEC    | compute result from A/B
//   S_WRITE   | done=1; stack/count/tos/flags commit on the closing edge
//   S_FAULT   | done=1, err=1 with err_code; nothing changes
module stack_logic_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    stack_logic_unit_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_DUP  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_B, S_EXEC, S_WRITE, S_FAULT
    } state_t;

    state_t           state;
    logic [3:0]       opc_q;
    logic [WIDTH-1:0] din_q, a_q, b_q, res_q, tos_q;
    logic [CW-1:0]    cnt_q;
    logic             rdy_q, done_q, err_q, zero_q, neg_q;
    logic [1:0]       ecode_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]    idx_top, idx_nos, idx_new, mem_wa;
    logic             full_w, mem_we;
    logic [1:0]       pre_err;
    logic [WIDTH-1:0] alu_res, wr_val;

    function automatic logic is_binary(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_NAND) || (op == OP_XOR) ||
               (op == OP_CMP) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    assign idx_top = IW'(cnt_q - CW'(1));
    assign idx_nos = IW'(cnt_q - CW'(2));
    assign idx_new = IW'(cnt_q);
    assign full_w  = (cnt_q == CW'(DEPTH));

    always_comb begin
        pre_err = 2'd0;
        if (bus.op_code >= 4'd12)
            pre_err = 2'd3;
        else if (is_binary(bus.op_code) && (cnt_q < CW'(2)))
            pre_err = 2'd1;
        else if (((bus.op_code == OP_POP) || (bus.op_code == OP_NOT) || (bus.op_code == OP_DUP))
                 && (cnt_q == '0))
            pre_err = 2'd1;
        else if (((bus.op_code == OP_PUSH) || (bus.op_code == OP_DUP)) && full_w)
            pre_err = 2'd2;
    end

    // B is next-of-stack, A is TOS; binary results are f(B, A). DUP passes A through.
    always_comb begin
        alu_res = a_q;
        case (opc_q)
            OP_AND:  alu_res = b_q & a_q;
            OP_OR:   alu_res = b_q | a_q;
            OP_NAND: alu_res = ~(b_q & a_q);
            OP_XOR:  alu_res = b_q ^ a_q;
            OP_NOR:  alu_res = ~(b_q | a_q);
            OP_XNOR: alu_res = ~(b_q ^ a_q);
            OP_NOT:  alu_res = ~a_q;
            OP_CMP: begin
                if ($signed(b_q) > $signed(a_q))
                    alu_res = WIDTH'(1);
                else if ($signed(b_q) < $signed(a_q))
                    alu_res = '1;
                else
                    alu_res = '0;
            end
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = idx_new;
        wr_val = (opc_q == OP_PUSH) ? din_q : res_q;
        if (state == S_WRITE) begin
            if ((opc_q == OP_PUSH) || (opc_q == OP_DUP)) begin
                mem_we = 1'b1;
            end else if (opc_q == OP_NOT) begin
                mem_we = 1'b1;
                mem_wa = idx_top;
            end else if (is_binary(opc_q)) begin
                mem_we = 1'b1;
                mem_wa = idx_nos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= wr_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            opc_q   <= '0;
            din_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            tos_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= 2'd0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= 2'd0;
            case (state)
                S_IDLE: begin
                    if (bus.op_valid && rdy_q) begin
                        opc_q <= bus.op_code;
                        din_q <= bus.din;
                        rdy_q <= 1'b0;
                        if (pre_err != 2'd0) begin
                            state   <= S_FAULT;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            ecode_q <= pre_err;
                        end else if ((bus.op_code == OP_NOP) || (bus.op_code == OP_PUSH)) begin
                            state  <= S_WRITE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_FETCH_A;
                        end
                    end
                end
                S_FETCH_A: begin
                    a_q <= mem[idx_top];
                    b_q <= (cnt_q >= CW'(2)) ? mem[idx_nos] : '0;
                    if (opc_q == OP_POP) begin
                        state  <= S_WRITE;
                        done_q <= 1'b1;
                    end else if (is_binary(opc_q)) begin
                        state <= S_FETCH_B;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_FETCH_B: begin
                    b_q   <= mem[idx_nos];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q  <= alu_res;
                    state  <= S_WRITE;
                    done_q <= 1'b1;
                end
                S_WRITE: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b1;
                    if ((opc_q == OP_PUSH) || (opc_q == OP_DUP)) begin
                        cnt_q  <= cnt_q + CW'(1);
                        tos_q  <= wr_val;
                        zero_q <= (wr_val == '0);
                        neg_q  <= wr_val[WIDTH-1];
                    end else if (opc_q == OP_POP) begin
                        cnt_q <= cnt_q - CW'(1);
                        tos_q <= b_q;
                    end else if ((opc_q == OP_NOT) || is_binary(opc_q)) begin
                        if (opc_q != OP_NOT)
                            cnt_q <= cnt_q - CW'(1);
                        tos_q  <= res_q;
                        zero_q <= (res_q == '0);
                        neg_q  <= res_q[WIDTH-1];
                    end
                end
                S_FAULT: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.op_ready = rdy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = ecode_q;
    assign bus.tos      = tos_q;
    assign bus.count    = cnt_q;
    assign bus.empty    = (cnt_q == '0);
    assign bus.full     = full_w;
    assign bus.zero     = zero_q;
    assign bus.neg      = neg_q;
endmodule
